add_serial: RTL and testbench
=============================

// Module: add_serial
// PURPOSE
// - Multi-cycle slice-serial adder: the addition counterpart to the ALU's combinational subtract path.
// - Returns sum = input_1 + input_2 + cin, plus carry-out and signed-overflow flags.
// - Sits between the ALU operand registers and the result bus.
// - Processes one SLICE-bit slice per clock, LSB slice first, with a ripple carry register between slices.
// PARAMETERS
// - WIDTH  8  operand/result width in bits; must be an integer multiple of SLICE.
// - SLICE  4  bits added per cycle; NSLICE = WIDTH/SLICE slices per operation.
// PORTS
// - clk           in   1      single clock; all state updates on the rising edge.
// - rst           in   1      synchronous, active-high reset.
// - in_valid      in   1      operands and cin present this cycle.
// - in_ready      out  1      block can accept operands.
// - input_1       in   WIDTH  addend A (two's complement or unsigned).
// - input_2       in   WIDTH  addend B.
// - cin           in   1      carry-in into bit 0.
// - out_valid     out  1      result held valid.
// - out_ready     in   1      consumer accepts the result.
// - add_out       out  WIDTH  sum.
// - add_carry     out  1      unsigned carry-out of the MSB.
// - add_overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB.
// BEHAVIOUR
// - Reset values (sync; rst wins over every other input):
//   - state = IDLE, in_ready = 1, out_valid = 0.
//   - add_out, add_carry, add_overflow = 0; slice counter = 0.
// - IDLE: in_ready = 1.
//   - On in_valid & in_ready: latch input_1, input_2 and cin; counter = 0; go to RUN.
//   - in_ready drops in the following cycle.
// - RUN: in_ready = 0, out_valid = 0.
//   - Each cycle adds slice[counter] of A and B plus the carry register.
//   - The slice sum is written into add_out[counter*SLICE +: SLICE]; the slice carry-out goes to the carry register.
//   - On the last slice (counter = NSLICE-1) the carry into the MSB is also captured; go to DONE.
// - DONE: out_valid = 1; add_out, add_carry and add_overflow are stable.
//   - On out_ready: go to IDLE; out_valid clears the following cycle.
//   - No out_ready: hold indefinitely; all outputs stay constant.
// - Latency: if operands are accepted at edge E0, out_valid is high in the cycle after edge E0+NSLICE.
//   - Default: out_valid high 3 cycles after the accept cycle.
// - Throughput: one operation per NSLICE+2 cycles minimum.
//   - in_ready is high only in IDLE; operands offered while busy are ignored, and no data is lost.
// - Arithmetic rules:
//   - Full modulo-2^WIDTH sum; no width extension.
//   - add_carry equals bit WIDTH of the (WIDTH+1)-bit sum.
//   - The flags are valid only while out_valid = 1.
// - Boundaries:
//   - Carry propagates across slice boundaries; cin = 1 is included in slice 0 only.
//   - Operand inputs are sampled only on the accept edge; changes during RUN or DONE have no effect.
//   - in_valid and out_ready both high in DONE: the result handshake completes and the new operands are NOT accepted that cycle.
//   - rst mid-RUN or in DONE: the operation is aborted, outputs return to reset values, and no out_valid pulse is produced.
// CONFIGURATION
// - Macro ADD_SATURATE_EN.
// - Defined: on signed overflow, add_out is clamped on the DONE transition.
//   - Positive overflow (both operand MSBs 0) gives 0111..1; negative overflow gives 1000..0.
//   - add_carry and add_overflow report the raw, unsaturated values.
// - Undefined: add_out is the wrapping modulo sum; no clamp logic is synthesized.
// TESTING
// - 0x3A + 0x15, cin=0 -> add_out=0x4F, carry=0, ovf=0; out_valid 3 cycles after accept.
// - 0x0F + 0x00, cin=1 -> 0x10, carry=0, ovf=0 (cin crosses the slice boundary).
// - 0xFF + 0x01, cin=0 -> 0x00, carry=1, ovf=0.
// - 0x7F + 0x01 -> 0x80, ovf=1, carry=0 (with ADD_SATURATE_EN: 0x7F); 0x80 + 0xFF -> 0x7F, carry=1, ovf=1 (saturated: 0x80).
// - Hold out_ready=0 for 10 cycles in DONE while toggling the inputs and in_valid.
//   - Required: result stable, in_ready=0, no new accept; out_ready=1 -> IDLE the next cycle.
// - rst asserted in the cycle after accept:
//   - Required: next cycle out_valid=0, add_out=0, in_ready=1.
//   - A subsequent 0x01 + 0x01 must give 0x02.

Source files
------------

// File: rtl/add_serial.sv
// Slice-serial adder: sum = input_1 + input_2 + cin, one SLICE-bit slice per clock, LSB first.
// Latency NSLICE+1 cycles from accept to out_valid; in_ready only in IDLE, result held until out_ready.
// Optional ADD_SATURATE_EN clamps add_out on signed overflow (flags stay raw).
module add_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_out,
  output logic             add_carry,
  output logic             add_overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   slice_sum;
  logic             ovf_final;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign a_sl      = a_q[int'(cnt)*SLICE +: SLICE];
  assign b_sl      = b_q[int'(cnt)*SLICE +: SLICE];
  assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

  // Carry into the MSB is a^b^sum at that bit, so overflow needs no extra adder tap.
  assign ovf_final = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[SLICE-1] ^ slice_sum[SLICE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      cnt          <= '0;
      add_out      <= '0;
      add_carry    <= 1'b0;
      add_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= input_1;
            b_q     <= input_2;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          add_out[int'(cnt)*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
          carry_q <= slice_sum[SLICE];
          if (cnt == LAST) begin
            add_carry    <= slice_sum[SLICE];
            add_overflow <= ovf_final;
            state        <= DONE;
`ifdef ADD_SATURATE_EN
            // Both operands share the MSB on overflow, so a_q's MSB gives the direction.
            if (ovf_final)
              add_out <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial.sv
// Randomized and directed bench for add_serial against a plain-arithmetic reference model.
module tb_add_serial;

  localparam int W      = 8;
  localparam int SL     = 4;
  localparam int NSLICE = W / SL;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_1;
  logic [W-1:0] input_2;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] add_out;
  logic         add_carry;
  logic         add_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  add_serial #(.WIDTH(W), .SLICE(SL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_1(input_1), .input_2(input_2), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .add_out(add_out), .add_carry(add_carry), .add_overflow(add_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain (W+1)-bit addition; overflow when equal-sign operands give a different-sign sum.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] eo, output logic ec, output logic ev);
    int unsigned s;
    s  = int'(a) + int'(b) + int'(c);
    eo = W'(s % (1 << W));
    ec = ((s >> W) & 1) != 0;
    ev = (a[W-1] == b[W-1]) && (eo[W-1] != a[W-1]);
`ifdef ADD_SATURATE_EN
    if (ev) eo = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  endtask

  // Full transaction; inputs are scrambled after accept to prove they are not re-sampled.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int hold, input string tag);
    logic [W-1:0] eo;
    logic         ec;
    logic         ev;
    int           k;
    model(a, b, c, eo, ec, ev);
    chk({tag, "_rdy_idle"}, in_ready, 1);
    input_1 = a; input_2 = b; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    input_1 = W'($urandom); input_2 = W'($urandom); cin = 1'($urandom);
    chk({tag, "_rdy_busy"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, k, NSLICE);
    repeat (hold) step();
    chk({tag, "_sum"}, add_out, eo);
    chk({tag, "_carry"}, add_carry, ec);
    chk({tag, "_ovf"}, add_overflow, ev);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         hc;
    logic         hv;
    logic [W-1:0] eo;
    logic         ec;
    logic         ev;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    input_1 = '0; input_2 = '0; cin = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_add_out", add_out, 0);
    chk("rst_carry", add_carry, 0);
    chk("rst_ovf", add_overflow, 0);

    run_op(8'h3A, 8'h15, 1'b0, 0, "d3a15");
    run_op(8'h0F, 8'h00, 1'b1, 0, "d0f_cin");
    run_op(8'hFF, 8'h01, 1'b0, 1, "dff01");
    run_op(8'h7F, 8'h01, 1'b0, 0, "d7f01");
    run_op(8'h80, 8'hFF, 1'b0, 2, "d80ff");
    run_op(8'hFF, 8'hFF, 1'b1, 0, "dffff_cin");

    // Hold in DONE with busy inputs toggling.
    input_1 = 8'h12; input_2 = 8'h34; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    model(8'h12, 8'h34, 1'b1, eo, ec, ev);
    chk("hold_enter_vld", out_valid, 1);
    held = add_out; hc = add_carry; hv = add_overflow;
    chk("hold_sum", held, eo);
    for (int i = 0; i < 10; i++) begin
      input_1 = W'($urandom); input_2 = W'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      step();
      chk("hold_vld", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
      chk("hold_stable", {add_overflow, add_carry, add_out}, {hv, hc, held});
    end
    // Result handshake and in_valid together: new operands must not be taken.
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("hs_vld_clr", out_valid, 0);
    chk("hs_rdy_idle", in_ready, 1);
    step();
    chk("hs_no_accept", in_ready, 1);

    // Reset one cycle after accept aborts the operation.
    input_1 = 8'h55; input_2 = 8'h66; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_vld", out_valid, 0);
    chk("abort_sum", add_out, 0);
    chk("abort_rdy", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_pulse", out_valid, 0);
      step();
    end
    run_op(8'h01, 8'h01, 1'b0, 0, "post_rst");

    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
